// File: rtl/shift_arbiter.sv
// shift_arbiter: shares one external combinational shifter between two
// requesters. Grants one request, registers its operands onto the shifter
// inputs, captures the shifter result and returns it with the requester ID
// over a valid/ready response channel.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for a request; the winner's ready is driven combinationally
// SHIFT | shifter settling on the registered operands
// RESP  | result held on rsp_* until the consumer takes it
module shift_arbiter #(
    parameter int WIDTH      = 16,
    parameter int AMTW       = 4,
    parameter int FIXED_PRIO = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_data,
    input  logic             req0_dir,
    input  logic [AMTW-1:0]  req0_amt,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_data,
    input  logic             req1_dir,
    input  logic [AMTW-1:0]  req1_amt,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_id,
    output logic [WIDTH-1:0] sh_a,
    output logic             sh_ir,
    output logic [AMTW-1:0]  sh_amt,
    input  logic [WIDTH-1:0] sh_y
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_a_q, sh_a_d;
    logic             sh_ir_q, sh_ir_d;
    logic [AMTW-1:0]  sh_amt_q, sh_amt_d;
    logic             id_q, id_d;
    logic             last_q, last_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_id_q, rsp_id_d;

    logic grant;
    logic accept;

    // Grant selection: a lone request wins; on a tie either requester 0
    // (fixed priority) or whoever was not granted last.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = (FIXED_PRIO != 0) ? 1'b0 : ~last_q;
        end else begin
            grant = ~req0_valid;
        end
    end

    // Acceptance only in IDLE; gated by rst so readys show reset values
    // for the whole time reset is held.
    always_comb begin
        accept     = (state_q == IDLE) && (req0_valid || req1_valid) && !rst;
        req0_ready = accept && !grant;
        req1_ready = accept && grant;
    end

    // Next-state and register-update logic.
    always_comb begin
        state_d     = state_q;
        sh_a_d      = sh_a_q;
        sh_ir_d     = sh_ir_q;
        sh_amt_d    = sh_amt_q;
        id_d        = id_q;
        last_d      = last_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    sh_a_d   = grant ? req1_data : req0_data;
                    sh_ir_d  = grant ? req1_dir  : req0_dir;
                    sh_amt_d = grant ? req1_amt  : req0_amt;
                    id_d     = grant;
                    last_d   = grant;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                rsp_data_d  = sh_y;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State and datapath registers; last grant resets to 1 so requester 0
    // wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sh_a_q      <= '0;
            sh_ir_q     <= 1'b0;
            sh_amt_q    <= '0;
            id_q        <= 1'b0;
            last_q      <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_a_q      <= sh_a_d;
            sh_ir_q     <= sh_ir_d;
            sh_amt_q    <= sh_amt_d;
            id_q        <= id_d;
            last_q      <= last_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    assign sh_a      = sh_a_q;
    assign sh_ir     = sh_ir_q;
    assign sh_amt    = sh_amt_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;

endmodule
